// File: rtl/traffic_light_fsm_if.sv
// Bundle of the controller's tick/request inputs and its light/countdown outputs.
// The controller connects through the slave modport; the stimulus side uses master.
interface traffic_light_fsm_if;
    logic       tick;
    logic       ew_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] remain;
    logic [2:0] phase;

    modport master (
        output tick,
        output ew_req,
        input  ns_light,
        input  ew_light,
        input  remain,
        input  phase
    );

    modport slave (
        input  tick,
        input  ew_req,
        output ns_light,
        output ew_light,
        output remain,
        output phase
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller: NS main road, EW side road, tick-driven phase timing.
// Side-road green is skipped while no EW vehicle has been seen.
module traffic_light_fsm #(
    parameter int unsigned GREEN_T  = 25,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_light_fsm_if.slave   bus
);

    localparam logic [7:0] GreenT  = 8'(GREEN_T);
    localparam logic [7:0] YellowT = 8'(YELLOW_T);
    localparam logic [7:0] AllredT = 8'(ALLRED_T);

    localparam logic [2:0] LightRed    = 3'b100;
    localparam logic [2:0] LightYellow = 3'b010;
    localparam logic [2:0] LightGreen  = 3'b001;

    typedef enum logic [2:0] {
        NsGreen  = 3'd0,
        NsYellow = 3'd1,
        RedToEw  = 3'd2,
        EwGreen  = 3'd3,
        EwYellow = 3'd4,
        RedToNs  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic       req_latch_q, req_latch_d;
    logic       expire;
    logic [2:0] ns_light, ew_light;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RedToNs;
            remain_q    <= AllredT;
            req_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            req_latch_q <= req_latch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        req_latch_d = req_latch_q | bus.ew_req;
        // Treat a (never expected) zero count like one so remain cannot wrap.
        expire      = bus.tick && (remain_q <= 8'd1);

        if (bus.tick && (remain_q > 8'd1)) begin
            remain_d = remain_q - 8'd1;
        end

        case (state_q)
            NsGreen: begin
                if (expire) begin
                    // Without a waiting side-road vehicle, re-arm green instead of yielding.
                    if (req_latch_q || bus.ew_req) begin
                        state_d  = NsYellow;
                        remain_d = YellowT;
                    end else begin
                        remain_d = GreenT;
                    end
                end
            end
            NsYellow: begin
                if (expire) begin
                    state_d  = RedToEw;
                    remain_d = AllredT;
                end
            end
            RedToEw: begin
                if (expire) begin
                    state_d     = EwGreen;
                    remain_d    = GreenT;
                    req_latch_d = bus.ew_req;
                end
            end
            EwGreen: begin
                if (expire) begin
                    state_d  = EwYellow;
                    remain_d = YellowT;
                end
            end
            EwYellow: begin
                if (expire) begin
                    state_d  = RedToNs;
                    remain_d = AllredT;
                end
            end
            RedToNs: begin
                if (expire) begin
                    state_d  = NsGreen;
                    remain_d = GreenT;
                end
            end
            default: begin
                state_d  = RedToNs;
                remain_d = AllredT;
            end
        endcase
    end

    // Lights depend on the state register alone, so inputs never glitch them.
    always_comb begin
        ns_light = LightRed;
        ew_light = LightRed;
        case (state_q)
            NsGreen:  ns_light = LightGreen;
            NsYellow: ns_light = LightYellow;
            EwGreen:  ew_light = LightGreen;
            EwYellow: ew_light = LightYellow;
            default: begin
                ns_light = LightRed;
                ew_light = LightRed;
            end
        endcase
    end

    assign bus.ns_light = ns_light;
    assign bus.ew_light = ew_light;
    assign bus.remain   = remain_q;
    assign bus.phase    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised and directed checks of traffic_light_fsm against a table-driven phase model.
module tb_traffic_light_fsm;

    localparam int unsigned G = 4;
    localparam int unsigned Y = 2;
    localparam int unsigned A = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    traffic_light_fsm_if bus ();

    traffic_light_fsm #(
        .GREEN_T  (G),
        .YELLOW_T (Y),
        .ALLRED_T (A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: position in the fixed phase cycle, ticks left, and the pending side-road request.
    int m_pos;
    int m_rem;
    bit m_req;

    int         dur_tab [6] = '{G, Y, A, G, Y, A};
    logic [2:0] ns_tab  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", tag, $time);
    endtask

    function automatic void model_reset();
        m_pos = 5;
        m_rem = A;
        m_req = 1'b0;
    endfunction

    function automatic void model_step(input bit t, input bit r);
        bit req_now;
        req_now = m_req | r;
        if (t && m_rem == 1) begin
            if (m_pos == 0 && !req_now) begin
                m_rem = G;
                m_req = req_now;
            end else begin
                m_pos = (m_pos + 1) % 6;
                m_rem = dur_tab[m_pos];
                m_req = (m_pos == 3) ? r : req_now;
            end
        end else begin
            if (t) m_rem = m_rem - 1;
            m_req = req_now;
        end
    endfunction

    task automatic check_all();
        check_eq("ns_light",  32'(bus.ns_light), 32'(ns_tab[m_pos]));
        check_eq("ew_light",  32'(bus.ew_light), 32'(ew_tab[m_pos]));
        check_eq("remain",    32'(bus.remain), 32'(m_rem));
        check_eq("phase",     32'(bus.phase), 32'(m_pos));
        check_eq("req_latch", 32'(dut.req_latch_q), 32'(m_req));
        check_eq("ns_onehot", 32'($onehot(bus.ns_light)), 32'd1);
        check_eq("ew_onehot", 32'($onehot(bus.ew_light)), 32'd1);
        check_eq("both_go",   32'(bus.ns_light != 3'b100 && bus.ew_light != 3'b100), 32'd0);
    endtask

    task automatic step(input bit t, input bit r);
        bus.tick   = t;
        bus.ew_req = r;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(t, r);
        #1;
        check_all();
        cyc++;
    endtask

    function automatic bit tick_now();
        return (cyc % 3) == 0;
    endfunction

    // Reset asserted between clock edges; outputs must respond before the next edge.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_until_pos(input int pos, input int bound, input string tag);
        int guard = 0;
        while (m_pos != pos && guard < bound) begin
            step(tick_now(), 1'b0);
            guard++;
        end
        if (m_pos != pos) timeout(tag);
    endtask

    initial begin
        int guard;
        bus.tick   = 1'b0;
        bus.ew_req = 1'b0;
        reset      = 1'b1;
        model_reset();
        #3;
        check_all();
        step(1'b0, 1'b0);
        reset = 1'b0;

        // No side-road demand: NS green re-arms indefinitely.
        for (int i = 0; i < 40; i++) step(tick_now(), 1'b0);
        check_eq("s1_ns_green_hold", 32'(bus.phase), 32'd0);

        // Single-clock request pulse gives one full EW service.
        step(tick_now(), 1'b1);
        for (int i = 0; i < 60; i++) step(tick_now(), 1'b0);
        check_eq("s2_back_ns_green", 32'(bus.phase), 32'd0);

        // Request seen only on the expiring tick still yields this edge.
        guard = 0;
        while (!(m_pos == 0 && m_rem == 1 && tick_now()) && guard < 30) begin
            step(tick_now(), 1'b0);
            guard++;
        end
        if (!(m_pos == 0 && m_rem == 1)) timeout("s3_reach_expiry");
        step(1'b1, 1'b1);
        check_eq("s3_yellow_now", 32'(bus.phase), 32'd1);
        run_until_pos(0, 100, "s3_return");

        // Request held through EW green entry keeps the latch set.
        guard = 0;
        while (m_pos != 4 && guard < 200) begin
            step(tick_now(), 1'b1);
            guard++;
        end
        if (m_pos != 4) timeout("s4_reach_ew_yellow");
        check_eq("s4_latch_kept", 32'(dut.req_latch_q), 32'd1);
        run_until_pos(0, 100, "s4_reach_ns_green");
        run_until_pos(1, 100, "s4_reach_ns_yellow");
        check_eq("s4_yield_after_green", 32'(bus.phase), 32'd1);
        run_until_pos(0, 100, "s4_return");

        // Reset in the middle of EW green.
        step(tick_now(), 1'b1);
        guard = 0;
        while (!(m_pos == 3 && m_rem == 2) && guard < 100) begin
            step(tick_now(), 1'b0);
            guard++;
        end
        if (!(m_pos == 3 && m_rem == 2)) timeout("s5_reach_ew_green");
        async_reset_pulse();
        check_eq("s5_remain_after_reset", 32'(bus.remain), 32'(A));
        run_until_pos(0, 20, "s5_resume");

        // Back-to-back ticks each count; the first carries a request.
        guard = 0;
        while (!(m_pos == 0 && m_rem == G) && guard < 30) begin
            step(tick_now(), 1'b0);
            guard++;
        end
        if (!(m_pos == 0 && m_rem == G)) timeout("s6_reach_full_green");
        step(1'b1, 1'b1);
        check_eq("s6_rem3", 32'(bus.remain), 32'd3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("s6_rem1", 32'(bus.remain), 32'd1);
        step(1'b1, 1'b0);
        check_eq("s6_yellow", 32'(bus.phase), 32'd1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset_pulse();
            end else begin
                step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
